// File: rtl/timing_sequence_gen.sv
// rtl/timing_sequence_gen.sv - parametrised controller sequence counter with one-hot timing decode
// Tracks completed sequences, auto-wrap pulse, saturate parking and sticky illegal-load flag.
module timing_sequence_gen #(
  parameter int unsigned CNT_WIDTH     = 4,
  parameter int unsigned LAST_STATE    = 15,
  parameter int unsigned SATURATE      = 0,
  parameter int unsigned SEQ_CNT_WIDTH = 16
) (
  input  logic                        clk_controller,
  input  logic                        rst_controller,
  input  logic                        inc_controller_counter,
  input  logic                        clr_controller_counter,
  input  logic                        hold_controller_counter,
  input  logic                        load_controller_counter,
  input  logic [CNT_WIDTH-1:0]        load_value,
  output logic [CNT_WIDTH-1:0]        state_counter,
  output logic [(1<<CNT_WIDTH)-1:0]   timing_signals,
  output logic                        seq_wrap,
  output logic                        seq_done,
  output logic [SEQ_CNT_WIDTH-1:0]    cycle_count,
  output logic                        illegal_load
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LAST_STATE);

  logic [CNT_WIDTH-1:0]     state_q, state_d;
  logic                     wrap_q, wrap_d;
  logic [SEQ_CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic                     illegal_q, illegal_d;

  always_ff @(posedge clk_controller) begin
    if (rst_controller) begin
      state_q   <= '0;
      wrap_q    <= 1'b0;
      cycle_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wrap_q    <= wrap_d;
      cycle_q   <= cycle_d;
      illegal_q <= illegal_d;
    end
  end

  // Priority: clear, load, hold, terminal-state handling, increment.
  always_comb begin
    state_d   = state_q;
    wrap_d    = wrap_q;
    cycle_d   = cycle_q;
    illegal_d = illegal_q;
    if (clr_controller_counter) begin
      state_d   = '0;
      cycle_d   = cycle_q + SEQ_CNT_WIDTH'(1);
      illegal_d = 1'b0;
      wrap_d    = 1'b0;
    end else if (load_controller_counter) begin
      wrap_d = 1'b0;
      if (load_value <= LAST) begin
        state_d = load_value;
      end else begin
        illegal_d = 1'b1;
      end
    end else if (!hold_controller_counter) begin
      wrap_d = 1'b0;
      if (state_q == LAST) begin
        if (SATURATE == 0) begin
          state_d = '0;
          cycle_d = cycle_q + SEQ_CNT_WIDTH'(1);
          wrap_d  = 1'b1;
        end
      end else if (inc_controller_counter) begin
        state_d = state_q + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    timing_signals          = '0;
    timing_signals[state_q] = 1'b1;
  end

  assign state_counter = state_q;
  assign seq_wrap      = wrap_q;
  assign seq_done      = (SATURATE != 0) && (state_q == LAST);
  assign cycle_count   = cycle_q;
  assign illegal_load  = illegal_q;

endmodule

// File: tb/tb_timing_sequence_gen.sv
// tb/tb_timing_sequence_gen.sv - directed scoreboard bench for timing_sequence_gen
// Three instances: defaults, LAST_STATE=5 wrapping (2-bit cycle count), LAST_STATE=5 saturating.
module tb_timing_sequence_gen;

  logic       clk = 1'b0;
  logic       rst, inc, clr, hold, load;
  logic [3:0] lv;

  logic [3:0]  st0, st1, st2;
  logic [15:0] ts0, ts1, ts2;
  logic        wr0, wr1, wr2, dn0, dn1, dn2, il0, il1, il2;
  logic [15:0] cc0, cc2;
  logic [1:0]  cc1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          d;
    int          st;
    bit          wrap;
    bit          done;
    int          cnt;
    bit          ill;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  timing_sequence_gen u_d (
    .clk_controller(clk), .rst_controller(rst), .inc_controller_counter(inc),
    .clr_controller_counter(clr), .hold_controller_counter(hold),
    .load_controller_counter(load), .load_value(lv), .state_counter(st0),
    .timing_signals(ts0), .seq_wrap(wr0), .seq_done(dn0), .cycle_count(cc0),
    .illegal_load(il0));

  timing_sequence_gen #(.LAST_STATE(5), .SATURATE(0), .SEQ_CNT_WIDTH(2)) u_w (
    .clk_controller(clk), .rst_controller(rst), .inc_controller_counter(inc),
    .clr_controller_counter(clr), .hold_controller_counter(hold),
    .load_controller_counter(load), .load_value(lv), .state_counter(st1),
    .timing_signals(ts1), .seq_wrap(wr1), .seq_done(dn1), .cycle_count(cc1),
    .illegal_load(il1));

  timing_sequence_gen #(.LAST_STATE(5), .SATURATE(1)) u_s (
    .clk_controller(clk), .rst_controller(rst), .inc_controller_counter(inc),
    .clr_controller_counter(clr), .hold_controller_counter(hold),
    .load_controller_counter(load), .load_value(lv), .state_counter(st2),
    .timing_signals(ts2), .seq_wrap(wr2), .seq_done(dn2), .cycle_count(cc2),
    .illegal_load(il2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit i, input bit c, input bit h, input bit l,
                       input int v);
    rst = r; inc = i; clr = c; hold = h; load = l; lv = 4'(v);
  endtask

  task automatic push(input string tag, input int d, input int st, input bit wrap,
                      input bit done, input int cnt, input bit ill);
    exp_t e;
    e.tag = tag; e.d = d; e.st = st; e.wrap = wrap; e.done = done; e.cnt = cnt; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic [31:0] o_st, o_ts, o_wr, o_dn, o_cc, o_il;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.d)
        0:       begin o_st = 32'(st0); o_ts = 32'(ts0); o_wr = 32'(wr0); o_dn = 32'(dn0); o_cc = 32'(cc0); o_il = 32'(il0); end
        1:       begin o_st = 32'(st1); o_ts = 32'(ts1); o_wr = 32'(wr1); o_dn = 32'(dn1); o_cc = 32'(cc1); o_il = 32'(il1); end
        default: begin o_st = 32'(st2); o_ts = 32'(ts2); o_wr = 32'(wr2); o_dn = 32'(dn2); o_cc = 32'(cc2); o_il = 32'(il2); end
      endcase
      chk({e.tag, ".state"},   o_st, 32'(e.st));
      chk({e.tag, ".timing"},  o_ts, 32'(1) << e.st);
      chk({e.tag, ".wrap"},    o_wr, 32'(e.wrap));
      chk({e.tag, ".done"},    o_dn, 32'(e.done));
      chk({e.tag, ".cycles"},  o_cc, 32'(e.cnt));
      chk({e.tag, ".illegal"}, o_il, 32'(e.ill));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state of all instances
    drive(1, 0, 0, 0, 0, 0);
    push("rst_d", 0, 0, 0, 0, 0, 0);
    push("rst_w", 1, 0, 0, 0, 0, 0);
    push("rst_s", 2, 0, 0, 1'b0, 0, 0);
    tick();

    // Defaults: full 0..15 walk and auto-wrap
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      push($sformatf("walk%0d", k), 0, (k <= 15) ? k : k - 16, k == 16, 0, (k >= 16) ? 1 : 0, 0);
      tick();
    end

    // LAST_STATE=5 wrap vs saturate, including 2-bit cycle_count rollover
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      push($sformatf("wrap%0d", k), 1, k % 6, (k % 6) == 0, 0, (k / 6) % 4, 0);
      push($sformatf("sat%0d", k), 2, (k < 5) ? k : 5, 0, k >= 5, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0, 0, 0);
    push("sat_clr", 2, 0, 0, 0, 1, 0);
    push("wrap_clr", 1, 0, 0, 0, 1, 0);
    tick();

    // Hold mid-sequence and at LAST_STATE
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      push($sformatf("pre_hold%0d", k), 0, k, 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      push($sformatf("hold3_d%0d", k), 0, 3, 0, 0, 0, 0);
      push($sformatf("hold3_w%0d", k), 1, 3, 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 4; k <= 5; k++) begin
      push($sformatf("post_hold%0d", k), 1, k, 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      push($sformatf("hold_last%0d", k), 1, 5, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    push("release_w", 1, 0, 1, 0, 1, 0);
    push("release_d", 0, 5, 0, 0, 0, 0);
    tick();
    push("after_wrap_w", 1, 0, 0, 0, 1, 0);
    tick();

    // Loads: legal, illegal, under hold, together with clear, at LAST_STATE
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 9);
    push("load9_d", 0, 9, 0, 0, 0, 0);
    push("load9_w", 1, 0, 0, 0, 0, 1);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    push("inc_d", 0, 10, 0, 0, 0, 0);
    push("sticky_w", 1, 1, 0, 0, 0, 1);
    tick();
    drive(0, 1, 0, 1, 1, 3);
    push("load_hold_d", 0, 3, 0, 0, 0, 0);
    push("load_hold_w", 1, 3, 0, 0, 0, 1);
    tick();
    drive(0, 1, 1, 0, 1, 2);
    push("clr_load_d", 0, 0, 0, 0, 1, 0);
    push("clr_load_w", 1, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 5);
    push("load_last_w", 1, 5, 0, 0, 1, 0);
    push("load_last_s", 2, 5, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    push("idle_w", 1, 0, 1, 0, 2, 0);
    push("idle_d", 0, 5, 0, 0, 1, 0);
    push("idle_s", 2, 5, 0, 1, 1, 0);
    tick();

    // Mid-sequence reset overriding everything else
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0, 0);
    push("clr_only_d", 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 1, 7);
    push("load7_d", 0, 7, 0, 0, 1, 0);
    push("load7_w", 1, 0, 0, 0, 1, 1);
    tick();
    drive(1, 1, 0, 1, 1, 9);
    push("midrst_d", 0, 0, 0, 0, 0, 0);
    push("midrst_w", 1, 0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
